scoot_arena_ctrl: RTL

- Synthesizable arena sequencer for one evolved scootBot.
- Holds a WIDTH x HEIGHT food map and drives the bot's four neighbour-sense inputs each step.
- Waits a fixed settle window, samples the bot's four move outputs, updates the bot position on a torus and clears/scores food on pickup.
- Runs NUM_STEPS steps and reports the final score; this is the fitness-evaluation engine used in place of a behavioural harness.

---
 rtl/scoot_arena_pkg.sv | 30 +++
 rtl/scoot_arena_ctrl_grid_wrap_step.sv | 20 ++
 rtl/scoot_arena_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/scoot_arena_pkg.sv
// Shared definitions for the scootBot arena sequencer: FSM encodings,
// default geometry and torus wrap helpers.
package scoot_arena_pkg;

  localparam int DEF_WIDTH         = 10;
  localparam int DEF_HEIGHT        = 10;
  localparam int DEF_NUM_STEPS     = 100;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SCORE_W       = 8;

  localparam int DEF_XW = $clog2(DEF_WIDTH);
  localparam int DEF_YW = $clog2(DEF_HEIGHT);
  localparam int DEF_CX = DEF_WIDTH / 2;
  localparam int DEF_CY = DEF_HEIGHT / 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SENSE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_MOVE   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int wrap_inc(input int c, input int lim);
    return (c >= lim - 1) ? 0 : c + 1;
  endfunction

  function automatic int wrap_dec(input int c, input int lim);
    return (c <= 0) ? lim - 1 : c - 1;
  endfunction

endpackage

// File: rtl/scoot_arena_ctrl_grid_wrap_step.sv
// One-axis torus coordinate step: +1, -1 or hold; opposing requests cancel.
module grid_wrap_step
  import scoot_arena_pkg::*;
#(
  parameter int LIMIT = DEF_WIDTH,
  parameter int W     = $clog2(LIMIT)
) (
  input  logic [W-1:0] coord,
  input  logic         plus,
  input  logic         minus,
  output logic [W-1:0] coord_nxt
);

  always_comb begin
    coord_nxt = coord;
    if (plus && !minus)      coord_nxt = W'(wrap_inc(int'(coord), LIMIT));
    else if (minus && !plus) coord_nxt = W'(wrap_dec(int'(coord), LIMIT));
  end

endmodule

// File: rtl/scoot_arena_ctrl.sv
// Arena sequencer: senses food around the bot, waits a settle window, applies
// the bot's move on a torus, and scores pickups over a fixed number of steps.
module scoot_arena_ctrl
  import scoot_arena_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int NUM_STEPS     = DEF_NUM_STEPS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SCORE_W       = DEF_SCORE_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           load_en,
  input  logic [$clog2(WIDTH)-1:0]       load_row,
  input  logic [HEIGHT-1:0]              load_data,
  input  logic                           m_up,
  input  logic                           m_right,
  input  logic                           m_down,
  input  logic                           m_left,
  output logic                           l_up,
  output logic                           l_right,
  output logic                           l_down,
  output logic                           l_left,
  output logic [$clog2(WIDTH)-1:0]       pos_x,
  output logic [$clog2(HEIGHT)-1:0]      pos_y,
  output logic [SCORE_W-1:0]             score,
  output logic [$clog2(NUM_STEPS+1)-1:0] step_cnt,
  output logic                           pickup,
  output logic                           busy,
  output logic                           done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int SW = $clog2(NUM_STEPS + 1);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [XW-1:0] CX = XW'(WIDTH / 2);
  localparam logic [YW-1:0] CY = YW'(HEIGHT / 2);

  logic [2:0]                     state_q, state_d;
  logic [WIDTH-1:0][HEIGHT-1:0]   map_q, map_d, map_clr;
  logic [XW-1:0]                  pos_x_q, pos_x_d;
  logic [YW-1:0]                  pos_y_q, pos_y_d;
  logic [SCORE_W-1:0]             score_q, score_d;
  logic [SW-1:0]                  step_q, step_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [3:0]                     sense_q, sense_d;

  logic [XW-1:0] x_move, x_inc, x_dec;
  logic [YW-1:0] y_move, y_inc, y_dec;
  logic          food_here;

  grid_wrap_step #(.LIMIT(WIDTH), .W(XW)) u_x_move (
    .coord(pos_x_q), .plus(m_right), .minus(m_left), .coord_nxt(x_move));
  grid_wrap_step #(.LIMIT(HEIGHT), .W(YW)) u_y_move (
    .coord(pos_y_q), .plus(m_up), .minus(m_down), .coord_nxt(y_move));

  // Same wrap logic reused to find the four neighbour cells for the sensors.
  grid_wrap_step #(.LIMIT(WIDTH), .W(XW)) u_x_inc (
    .coord(pos_x_q), .plus(1'b1), .minus(1'b0), .coord_nxt(x_inc));
  grid_wrap_step #(.LIMIT(WIDTH), .W(XW)) u_x_dec (
    .coord(pos_x_q), .plus(1'b0), .minus(1'b1), .coord_nxt(x_dec));
  grid_wrap_step #(.LIMIT(HEIGHT), .W(YW)) u_y_inc (
    .coord(pos_y_q), .plus(1'b1), .minus(1'b0), .coord_nxt(y_inc));
  grid_wrap_step #(.LIMIT(HEIGHT), .W(YW)) u_y_dec (
    .coord(pos_y_q), .plus(1'b0), .minus(1'b1), .coord_nxt(y_dec));

  assign food_here = map_q[pos_x_q][pos_y_q];

  // Sensors must see the map after the current cell has been eaten.
  always_comb begin
    map_clr = map_q;
    map_clr[pos_x_q][pos_y_q] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    score_d = score_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    sense_d = sense_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_en && (int'(load_row) < WIDTH)) map_d[load_row] = load_data;
        if (start) begin
          pos_x_d = CX;
          pos_y_d = CY;
          score_d = '0;
          step_d  = '0;
          state_d = ST_SENSE;
        end
      end
      ST_SENSE: begin
        map_d = map_clr;
        if (food_here && (score_q != '1)) score_d = score_q + SCORE_W'(1);
        sense_d = {map_clr[pos_x_q][y_inc], map_clr[x_inc][pos_y_q],
                   map_clr[pos_x_q][y_dec], map_clr[x_dec][pos_y_q]};
        cnt_d   = CW'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_MOVE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_MOVE: begin
        pos_x_d = x_move;
        pos_y_d = y_move;
        step_d  = step_q + SW'(1);
        if (int'(step_q) + 1 >= NUM_STEPS) begin
          state_d = ST_DONE;
          sense_d = '0;
        end else begin
          state_d = ST_SENSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      map_q   <= '0;
      pos_x_q <= CX;
      pos_y_q <= CY;
      score_q <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      sense_q <= '0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      score_q <= score_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      sense_q <= sense_d;
    end
  end

  assign {l_up, l_right, l_down, l_left} = sense_q;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign score    = score_q;
  assign step_cnt = step_q;
  assign pickup   = (state_q == ST_SENSE) && food_here;
  assign busy     = (state_q == ST_SENSE) || (state_q == ST_SETTLE) || (state_q == ST_MOVE);
  assign done     = (state_q == ST_DONE);

endmodule
